// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg
// Shared helpers for the pipelined add/subtract unit.
//   seg_width() : bits handled by one pipeline segment (WIDTH / STAGES)
//   split_ok()  : true when WIDTH/STAGES describe a legal segmentation
package pipe_adder_pkg;

  function automatic int seg_width(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit split_ok(input int width, input int stages);
    return (width >= 2) && (stages >= 1) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/rca_seg.sv
// rca_seg
// Combinational SEG-bit ripple-carry segment built from full-adder cells.
// Ports:
//   a_seg, b_seg : segment operand bits
//   ci           : carry into the lowest bit
//   s_seg        : segment sum bits
//   co           : carry out of the top bit
//   c_msb_in     : carry into the top bit (used for signed overflow)
module rca_seg #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a_seg,
  input  logic [SEG-1:0] b_seg,
  input  logic           ci,
  output logic [SEG-1:0] s_seg,
  output logic           co,
  output logic           c_msb_in
);

  always_comb begin : fa_chain
    logic [SEG:0] c;
    c     = '0;
    s_seg = '0;
    c[0]  = ci;
    for (int i = 0; i < SEG; i++) begin
      s_seg[i] = a_seg[i] ^ b_seg[i] ^ c[i];
      c[i+1]   = (a_seg[i] & b_seg[i]) | (c[i] & (a_seg[i] ^ b_seg[i]));
    end
    co       = c[SEG];
    c_msb_in = c[SEG-1];
  end

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder
// Pipelined WIDTH-bit add/subtract unit. The carry chain is split into
// STAGES segments of SEG bits, each followed by a register rank. Operands
// are captured (already conditioned for subtract) on acceptance, so a
// result appears STAGES edges after the accepting edge.
// Ports:
//   clk, rst            : clock (rising edge), async active-high reset
//   in_valid, in_ready  : operand handshake (in_ready = global advance)
//   a, b, cin, sub      : operands; sub=0 -> a+b+cin, sub=1 -> a-b-cin
//   out_valid, out_ready: result handshake
//   sum, cout, ovf      : result, carry / not-borrow, signed overflow
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG = seg_width(WIDTH, STAGES);

  if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
    $fatal(1, "pipe_adder: WIDTH=%0d must be >= 2 and a multiple of STAGES=%0d",
           WIDTH, STAGES);
  end

  // Rank 0 is the operand capture; rank k+1 is the output of segment k.
  logic [STAGES:0]              vld_p;
  logic [STAGES:0]              c_p;
  logic [STAGES:0][WIDTH-1:0]   sum_p;
  logic [STAGES-1:0][WIDTH-1:0] a_p;
  logic [STAGES-1:0][WIDTH-1:0] b_p;
  logic                         ovf_p;

  logic [STAGES-1:0][SEG-1:0]   s_w;
  logic [STAGES-1:0]            co_w;
  logic [STAGES-1:0]            cmsb_w;
  logic [STAGES-1:0][WIDTH-1:0] sum_nxt;
  logic                         adv;

  // Whole pipeline moves together; a full output slot that is not being
  // taken freezes every rank, bubbles included.
  assign adv      = !vld_p[STAGES] || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    rca_seg #(.SEG(SEG)) u_seg (
      .a_seg    (a_p[k][k*SEG +: SEG]),
      .b_seg    (b_p[k][k*SEG +: SEG]),
      .ci       (c_p[k]),
      .s_seg    (s_w[k]),
      .co       (co_w[k]),
      .c_msb_in (cmsb_w[k])
    );
  end

  // De-skew: lower segments already computed ride along, segment k is
  // dropped into its slot.
  always_comb begin
    sum_nxt = '0;
    for (int k = 0; k < STAGES; k++) begin
      sum_nxt[k]               = sum_p[k];
      sum_nxt[k][k*SEG +: SEG] = s_w[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= '0;
      c_p   <= '0;
      sum_p <= '0;
      a_p   <= '0;
      b_p   <= '0;
      ovf_p <= 1'b0;
    end else if (adv) begin
      // p0: operand capture; subtract becomes a + ~b + !cin
      vld_p    <= {vld_p[STAGES-1:0], in_valid};
      a_p[0]   <= a;
      b_p[0]   <= b ^ {WIDTH{sub}};
      c_p[0]   <= cin ^ sub;
      sum_p[0] <= '0;
      // p1..pSTAGES: segment results and skewed operands
      for (int k = 0; k < STAGES; k++) begin
        c_p[k+1]   <= co_w[k];
        sum_p[k+1] <= sum_nxt[k];
      end
      for (int k = 0; k < STAGES - 1; k++) begin
        a_p[k+1] <= a_p[k];
        b_p[k+1] <= b_p[k];
      end
      ovf_p <= cmsb_w[STAGES-1] ^ co_w[STAGES-1];
    end
  end

  // Low bits of the last skew rank and the mid-chain MSB carries of
  // earlier segments have no consumer.
  logic unused_bits;
  assign unused_bits = ^{a_p[STAGES-1], b_p[STAGES-1], cmsb_w};

  assign out_valid = vld_p[STAGES];
  assign sum       = sum_p[STAGES];
  assign cout      = c_p[STAGES];
  assign ovf       = ovf_p;

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder
// Self-checking bench for pipe_adder (WIDTH=16, STAGES=4): directed corner
// cases, backpressure, reset mid-flight and a randomized regression checked
// against an arithmetic reference model through a scoreboard queue.
module tb_pipe_adder;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;
  localparam int N_RAND = 10000;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int n_cmp = 0;
  int n_bad = 0;
  int n_drained = 0;

  logic [17:0] sb[$];
  logic        was_stall = 1'b0;
  logic [17:0] held = '0;

  pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {cout, ovf, sum} from plain integer arithmetic.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic c, input logic s);
    int ua, ub, sa, sy, r, sr;
    logic co, ov;
    logic [15:0] sm;
    ua = int'(x);
    ub = int'(y);
    sa = int'($signed(x));
    sy = int'($signed(y));
    if (!s) begin
      r  = ua + ub + int'(c);
      sr = sa + sy + int'(c);
      co = (r > 65535);
    end else begin
      r  = ua - ub - int'(c);
      sr = sa - sy - int'(c);
      co = (r >= 0);
    end
    sm = r[15:0];
    ov = (sr > 32767) || (sr < -32768);
    return {co, ov, sm};
  endfunction

  // Scoreboard / protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    logic [17:0] e;
    if (!rst) begin
      check("in_ready_rule", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
      if (was_stall)
        check("stall_hold", {13'd0, out_valid, cout, ovf, sum}, {13'd0, 1'b1, held});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("extra_output", {31'd0, out_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("sb_sum",  {16'd0, sum},  {16'd0, e[15:0]});
          check("sb_cout", {31'd0, cout}, {31'd0, e[17]});
          check("sb_ovf",  {31'd0, ovf},  {31'd0, e[16]});
          n_drained++;
        end
      end
      if (in_valid && in_ready)
        sb.push_back(model(a, b, cin, sub));
      was_stall <= out_valid && !out_ready;
      held      <= {cout, ovf, sum};
    end else begin
      was_stall <= 1'b0;
    end
  end

  // Single operation into an empty pipe, out_ready high: result must show
  // exactly STAGES edges after the accepting edge.
  task automatic single(input string tag, input logic [15:0] xa, input logic [15:0] xb,
                        input logic xc, input logic xs,
                        input logic [15:0] es, input logic ec, input logic eo);
    @(posedge clk); #1;
    a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1;
    @(negedge clk);
    check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (STAGES - 1) @(posedge clk);
    @(negedge clk);
    check({tag, ".early"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".sum"},   {16'd0, sum},  {16'd0, es});
    check({tag, ".cout"},  {31'd0, cout}, {31'd0, ec});
    check({tag, ".ovf"},   {31'd0, ovf},  {31'd0, eo});
  endtask

  initial begin
    int j, d0, sent, guard;
    logic acc;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.sum",       {16'd0, sum},       32'd0);
    check("rst.cout",      {31'd0, cout},      32'd0);
    check("rst.ovf",       {31'd0, ovf},       32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst.in_ready", {31'd0, in_ready}, 32'd1);

    // Directed arithmetic corners
    single("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    single("ovf_pos",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    single("ovf_neg",  16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    single("sub_neg",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    single("sub_bin",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0);
    single("sub_pos",  16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);

    // Back-to-back with a three-cycle output stall
    @(posedge clk); #1;
    j = 0; d0 = n_drained;
    for (int cyc = 0; cyc < 30; cyc++) begin
      out_ready = !(cyc >= 6 && cyc <= 8);
      in_valid  = (j < 8);
      a   = 16'(j);
      b   = 16'(16'h0100 * j);
      cin = 1'b0; sub = 1'b0;
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) j++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp.accepted", j, 8);
    check("bp.drained",  n_drained - d0, 8);
    check("bp.sb_empty", sb.size(), 0);

    // Reset with three operations in flight
    a = 16'h1111; b = 16'h0101; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 16'h2222; b = 16'h0202;
    @(posedge clk); #1;
    a = 16'h3333; b = 16'h0303;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    sb.delete();
    #1;
    check("midrst.out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst.sum",       {16'd0, sum},       32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    single("post_rst", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);

    // Randomized regression with random backpressure
    @(posedge clk); #1;
    d0 = n_drained; sent = 0; guard = 0; acc = 1'b0;
    while (sent < N_RAND && guard < 60000) begin
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 4) != 0);
        a   = 16'($urandom);
        b   = 16'($urandom);
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
      guard++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("rand.sent", sent, N_RAND);
    for (int w = 0; w < 20 && (sb.size() != 0 || out_valid); w++) @(negedge clk);
    check("rand.sb_empty", sb.size(), 0);
    check("rand.drained",  n_drained - d0, sent);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
